// File: rtl/lowx_line_responder.sv
// Line-granular memory responder at the far end of the dlowX path.
// Serves one fill/writeback at a time after a fixed wait.
//
// Ports:
//   clk_i, rst_i           clock, async active-high reset
//   req_valid_i/ready_o    request handshake
//   req_addr_i             byte address (line offset bits ignored)
//   req_rw_i               0 = line read, 1 = line write
//   req_data_i             write line data
//   res_valid_o/ready_i    response handshake
//   res_data_o             read line, or echo of the written line
//   res_err_o              address out of range
//   rd_cnt_o, wr_cnt_o     completed read / write responses
module lowx_line_responder #(
  parameter int XLEN      = 32,
  parameter int BLK_SIZE  = 128,
  parameter int MEM_LINES = 1024,
  parameter int LATENCY   = 4,
  parameter logic [XLEN-1:0] BASE_ADDR =
    XLEN'(32'h8000_0000)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [XLEN-1:0]     req_addr_i,
  input  logic                req_rw_i,
  input  logic [BLK_SIZE-1:0] req_data_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [BLK_SIZE-1:0] res_data_o,
  output logic                res_err_o,
  output logic [31:0]         rd_cnt_o,
  output logic [31:0]         wr_cnt_o
);

  localparam int OFF_BITS = $clog2(BLK_SIZE / 8);
  localparam int IDX_W    = $clog2(MEM_LINES);
  localparam int LIDX_W   = XLEN - OFF_BITS;
  localparam logic [7:0] LAT = 8'(LATENCY);
  localparam logic [LIDX_W-1:0] LINES =
    LIDX_W'(MEM_LINES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;

  logic [XLEN-1:0]     addr_q;
  logic                rw_q;
  logic [BLK_SIZE-1:0] data_q;
  logic [7:0]          cnt;

  logic [BLK_SIZE-1:0] mem [MEM_LINES];

  // In IDLE the request is still on the inputs; with zero
  // latency it has to be decoded before it is registered.
  logic [XLEN-1:0]     op_addr;
  logic                op_rw;
  logic [BLK_SIZE-1:0] op_data;

  always_comb begin
    op_addr = addr_q;
    op_rw   = rw_q;
    op_data = data_q;
    if (state == S_IDLE) begin
      op_addr = req_addr_i;
      op_rw   = req_rw_i;
      op_data = req_data_i;
    end
  end

  logic [XLEN-1:0]     off;
  logic [LIDX_W-1:0]   line;
  logic [OFF_BITS-1:0] unused_lo;
  logic [IDX_W-1:0]    idx;
  logic                in_range;

  assign off = op_addr - BASE_ADDR;
  assign {line, unused_lo} = off;
  assign idx = line[IDX_W-1:0];
  assign in_range = (op_addr >= BASE_ADDR) &&
                    (line < LINES);

  logic enter_resp;

  always_comb begin
    enter_resp = 1'b0;
    unique case (state)
      S_IDLE: enter_resp = req_valid_i && (LAT == 8'd0);
      S_WAIT: enter_resp = (cnt == 8'd1);
      default: enter_resp = 1'b0;
    endcase
  end

  // Single commit point: a write lands only on the edge
  // that enters RESP, so a reset during WAIT drops it.
  logic commit;
  assign commit = enter_resp && op_rw &&
                  in_range && !rst_i;

  always_ff @(posedge clk_i) begin
    if (commit) mem[idx] <= op_data;
  end

  logic [BLK_SIZE-1:0] resp_line;

  always_comb begin
    resp_line = '0;
    if (in_range)
      resp_line = op_rw ? op_data : mem[idx];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      req_ready_o <= 1'b1;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_err_o   <= 1'b0;
      rd_cnt_o    <= '0;
      wr_cnt_o    <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      data_q      <= '0;
      cnt         <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i) begin
            addr_q      <= req_addr_i;
            rw_q        <= req_rw_i;
            data_q      <= req_data_i;
            cnt         <= LAT;
            req_ready_o <= 1'b0;
            if (enter_resp) begin
              state       <= S_RESP;
              res_valid_o <= 1'b1;
              res_data_o  <= resp_line;
              res_err_o   <= !in_range;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (enter_resp) begin
            state       <= S_RESP;
            res_valid_o <= 1'b1;
            res_data_o  <= resp_line;
            res_err_o   <= !in_range;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_RESP: begin
          if (res_ready_i) begin
            state       <= S_IDLE;
            res_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            if (rw_q) wr_cnt_o <= wr_cnt_o + 32'd1;
            else      rd_cnt_o <= rd_cnt_o + 32'd1;
          end
        end
        default: begin
          state       <= S_IDLE;
          req_ready_o <= 1'b1;
          res_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lowx_line_responder.sv
// Directed bench for lowx_line_responder.
// Unit 0 runs LATENCY=4, unit 1 runs LATENCY=0.
module tb_lowx_line_responder;

  logic         clk = 1'b0;
  logic         rst       [2];
  logic         req_valid [2];
  logic         req_ready [2];
  logic [31:0]  req_addr  [2];
  logic         req_rw    [2];
  logic [127:0] req_data  [2];
  logic         res_valid [2];
  logic         res_ready [2];
  logic [127:0] res_data  [2];
  logic         res_err   [2];
  logic [31:0]  rd_cnt    [2];
  logic [31:0]  wr_cnt    [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lowx_line_responder #(.LATENCY(4)) dut_a (
    .clk_i(clk), .rst_i(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_addr_i(req_addr[0]), .req_rw_i(req_rw[0]),
    .req_data_i(req_data[0]),
    .res_valid_o(res_valid[0]), .res_ready_i(res_ready[0]),
    .res_data_o(res_data[0]), .res_err_o(res_err[0]),
    .rd_cnt_o(rd_cnt[0]), .wr_cnt_o(wr_cnt[0])
  );

  lowx_line_responder #(.LATENCY(0)) dut_b (
    .clk_i(clk), .rst_i(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_addr_i(req_addr[1]), .req_rw_i(req_rw[1]),
    .req_data_i(req_data[1]),
    .res_valid_o(res_valid[1]), .res_ready_i(res_ready[1]),
    .res_data_o(res_data[1]), .res_err_o(res_err[1]),
    .rd_cnt_o(rd_cnt[1]), .wr_cnt_o(wr_cnt[1])
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // lat = posedges after the accept edge before valid is seen,
  // i.e. response in cycle T+1+lat.
  task automatic do_txn(input int u,
                        input logic rw,
                        input logic [31:0] addr,
                        input logic [127:0] wdata,
                        input int hold,
                        output logic [127:0] rdata,
                        output logic err,
                        output int lat);
    bit ok;
    logic [31:0] rc;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[u]) begin
        ok = 1;
        break;
      end
    end
    chk("req_ready_timeout", 128'(ok), 128'd1);
    req_valid[u] = 1'b1;
    req_rw[u]    = rw;
    req_addr[u]  = addr;
    req_data[u]  = wdata;
    @(posedge clk);
    #1 req_valid[u] = 1'b0;
    lat = 0;
    ok  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (res_valid[u]) begin
        ok = 1;
        break;
      end
      lat++;
    end
    chk("res_valid_timeout", 128'(ok), 128'd1);
    rdata = res_data[u];
    err   = res_err[u];
    rc    = rw ? wr_cnt[u] : rd_cnt[u];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 128'(res_valid[u]), 128'd1);
      chk("bp_data", res_data[u], rdata);
      chk("bp_err", 128'(res_err[u]), 128'(err));
      chk("bp_req_ready", 128'(req_ready[u]), 128'd0);
      chk("bp_cnt", 128'(rw ? wr_cnt[u] : rd_cnt[u]),
          128'(rc));
    end
    res_ready[u] = 1'b1;
    @(posedge clk);
    #1 res_ready[u] = 1'b0;
  endtask

  localparam logic [127:0] D1 =
    128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] P0   = 128'hA0A0_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] P1023 = 128'hB1B1_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999;
  localparam logic [127:0] OLD  = 128'h0DD0_0DD0_0DD0_0DD0_0DD0_0DD0_0DD0_0DD0;
  localparam logic [127:0] NEW  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] P6   = 128'h6666_5555_4444_3333_2222_1111_0000_FFFF;
  localparam logic [127:0] Q    = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

  logic [127:0] rd;
  logic         er;
  int           lt;

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u]       = 1'b1;
      req_valid[u] = 1'b0;
      req_addr[u]  = '0;
      req_rw[u]    = 1'b0;
      req_data[u]  = '0;
      res_ready[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 128'(req_ready[0]), 128'd1);
    chk("rst_res_valid", 128'(res_valid[0]), 128'd0);
    chk("rst_res_data", res_data[0], 128'd0);
    chk("rst_res_err", 128'(res_err[0]), 128'd0);
    chk("rst_rd_cnt", 128'(rd_cnt[0]), 128'd0);
    chk("rst_wr_cnt", 128'(wr_cnt[0]), 128'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // read after write
    do_txn(0, 1'b1, 32'h8000_0010, D1, 0, rd, er, lt);
    chk("t1_wr_lat", 128'(lt), 128'd4);
    chk("t1_wr_echo", rd, D1);
    chk("t1_wr_err", 128'(er), 128'd0);
    do_txn(0, 1'b0, 32'h8000_0010, '0, 0, rd, er, lt);
    chk("t1_rd_lat", 128'(lt), 128'd4);
    chk("t1_rd_data", rd, D1);
    chk("t1_rd_err", 128'(er), 128'd0);
    @(negedge clk);
    chk("t1_wr_cnt", 128'(wr_cnt[0]), 128'd1);
    chk("t1_rd_cnt", 128'(rd_cnt[0]), 128'd1);

    // backpressure: 10 cycles held off
    do_txn(0, 1'b0, 32'h8000_0010, '0, 10, rd, er, lt);
    chk("t2_data", rd, D1);
    @(negedge clk);
    chk("t2_rd_cnt", 128'(rd_cnt[0]), 128'd2);
    chk("t2_wr_cnt", 128'(wr_cnt[0]), 128'd1);

    // out of range, with first and last lines preloaded
    do_txn(0, 1'b1, 32'h8000_0000, P0, 0, rd, er, lt);
    do_txn(0, 1'b1, 32'h8000_3FF0, P1023, 0, rd, er, lt);
    chk("t3_last_line_err", 128'(er), 128'd0);
    do_txn(0, 1'b0, 32'h7FFF_FFF0, '0, 0, rd, er, lt);
    chk("t3_low_err", 128'(er), 128'd1);
    chk("t3_low_data", rd, 128'd0);
    do_txn(0, 1'b1, 32'h8000_4000, {128{1'b1}}, 0, rd, er, lt);
    chk("t3_high_err", 128'(er), 128'd1);
    chk("t3_high_data", rd, 128'd0);
    do_txn(0, 1'b0, 32'h8000_0000, '0, 0, rd, er, lt);
    chk("t3_line0", rd, P0);
    do_txn(0, 1'b0, 32'h8000_3FF0, '0, 0, rd, er, lt);
    chk("t3_line1023", rd, P1023);
    @(negedge clk);
    chk("t3_rd_cnt", 128'(rd_cnt[0]), 128'd5);
    chk("t3_wr_cnt", 128'(wr_cnt[0]), 128'd4);

    // reset two cycles after accepting a write
    do_txn(0, 1'b1, 32'h8000_0020, OLD, 0, rd, er, lt);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_rw[0]    = 1'b1;
    req_addr[0]  = 32'h8000_0020;
    req_data[0]  = NEW;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    chk("t5_wait_ready", 128'(req_ready[0]), 128'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst[0] = 1'b1;
    #1;
    chk("t5_req_ready", 128'(req_ready[0]), 128'd1);
    chk("t5_res_valid", 128'(res_valid[0]), 128'd0);
    chk("t5_res_data", res_data[0], 128'd0);
    chk("t5_res_err", 128'(res_err[0]), 128'd0);
    chk("t5_rd_cnt", 128'(rd_cnt[0]), 128'd0);
    chk("t5_wr_cnt", 128'(wr_cnt[0]), 128'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    do_txn(0, 1'b0, 32'h8000_0020, '0, 0, rd, er, lt);
    chk("t5_old_kept", rd, OLD);

    // low address bits ignored
    do_txn(0, 1'b1, 32'h8000_003C, P6, 0, rd, er, lt);
    do_txn(0, 1'b0, 32'h8000_0030, '0, 0, rd, er, lt);
    chk("t6_same_line", rd, P6);
    chk("t6_err", 128'(er), 128'd0);

    // zero latency, response ready tied high
    res_ready[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_rw[1]    = 1'b1;
    req_addr[1]  = 32'h8000_0040;
    req_data[1]  = Q;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t4_valid_t1", 128'(res_valid[1]), 128'd1);
    chk("t4_ready_t1", 128'(req_ready[1]), 128'd0);
    chk("t4_echo", res_data[1], Q);
    @(negedge clk);
    chk("t4_valid_t2", 128'(res_valid[1]), 128'd0);
    chk("t4_ready_t2", 128'(req_ready[1]), 128'd1);
    chk("t4_wr_cnt", 128'(wr_cnt[1]), 128'd1);
    res_ready[1] = 1'b0;
    do_txn(1, 1'b0, 32'h8000_0040, '0, 0, rd, er, lt);
    chk("t4_rd_lat", 128'(lt), 128'd0);
    chk("t4_rd_data", rd, Q);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
